// File: rtl/charattr_row_reader_pkg.sv
`default_nettype none
// ============================================================================
// charattr_row_reader_pkg : row-reader constants, FSM encoding, cell layout
// Rev 1.0
// ============================================================================
package charattr_row_reader_pkg;

  localparam int COLUMNS    = 80;
  localparam int ADDR_WIDTH = 7;
  localparam int DATA_WIDTH = 32;

  // Cell layout: character code in the low half, attributes in the high half.
  localparam int CHAR_WIDTH = 16;
  localparam int ATTR_WIDTH = DATA_WIDTH - CHAR_WIDTH;

  typedef struct packed {
    logic [ATTR_WIDTH-1:0] attr;
    logic [CHAR_WIDTH-1:0] chr;
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/charattr_cell_fifo.sv
`default_nettype none
// ============================================================================
// charattr_cell_fifo : 2-entry synchronous FIFO of {column, cell} with flush
// Rev 1.0
// ============================================================================
module charattr_cell_fifo
  import charattr_row_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_col,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] head_col,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic [DATA_WIDTH-1:0] data_d [2];
  logic [ADDR_WIDTH-1:0] col_q  [2];
  logic [ADDR_WIDTH-1:0] col_d  [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q,  count_d;
  logic                  do_pop;

  assign do_pop = pop & (count_q != 2'd0);

  always_comb begin
    data_d   = data_q;
    col_d    = col_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Flush only rewinds the pointers; stale entries are never visible as valid.
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = push_data;
        col_d[wr_ptr_q]  = push_col;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      col_q[0]  <= '0;
      col_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      data_q    <= data_d;
      col_q     <= col_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign head_data = data_q[rd_ptr_q];
  assign head_col  = col_q[rd_ptr_q];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/charattr_row_reader.sv
`default_nettype none
// ============================================================================
// charattr_row_reader : scans one text row out of the char/attr buffer per line
// Rev 1.0
// ============================================================================
module charattr_row_reader
  import charattr_row_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  cell_valid,
  input  logic                  cell_ready,
  output logic [DATA_WIDTH-1:0] cell_data,
  output logic [ADDR_WIDTH-1:0] cell_col,
  output logic                  cell_last,
  output logic                  busy,
  output logic                  line_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(COLUMNS - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_col_q, inflight_col_d;
  logic                  line_done_q, line_done_d;

  logic [1:0]            fifo_count;
  logic                  pop;
  logic                  issue;
  logic [2:0]            credit_used;

  assign pop         = cell_valid & cell_ready;
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q};
  // A read is only launched if its data is guaranteed a FIFO slot on arrival.
  assign issue       = (state_q == ST_FETCH) & ~line_start &
                       (credit_used < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d        = state_q;
    ram_addr_d     = ram_addr_q;
    inflight_d     = issue;
    inflight_col_d = issue ? ram_addr_q : inflight_col_q;
    line_done_d    = (state_q == ST_DRAIN) & pop & cell_last;

    if (line_start) begin
      state_d    = ST_FETCH;
      ram_addr_d = '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (issue) begin
            if (ram_addr_q == LAST_COL) begin
              state_d = ST_DRAIN;
            end else begin
              ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (pop & cell_last) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      ram_addr_q     <= '0;
      inflight_q     <= 1'b0;
      inflight_col_q <= '0;
      line_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ram_addr_q     <= ram_addr_d;
      inflight_q     <= inflight_d;
      inflight_col_q <= inflight_col_d;
      line_done_q    <= line_done_d;
    end
  end

  // Read data for the in-flight address is on ram_data now; an abort drops it.
  charattr_cell_fifo u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (line_start),
    .push      (inflight_q),
    .push_col  (inflight_col_q),
    .push_data (ram_data),
    .pop       (pop),
    .head_col  (cell_col),
    .head_data (cell_data),
    .count     (fifo_count)
  );

  assign ram_addr   = ram_addr_q;
  assign cell_valid = (fifo_count != 2'd0);
  assign cell_last  = (cell_col == LAST_COL);
  assign busy       = (state_q != ST_IDLE);
  assign line_done  = line_done_q;

endmodule
`default_nettype wire

// File: tb/tb_charattr_row_reader.sv
`default_nettype none
// ============================================================================
// tb_charattr_row_reader : directed self-checking bench for charattr_row_reader
// Rev 1.0
// ============================================================================
module tb_charattr_row_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [6:0]  ram_addr;
  logic [31:0] ram_data;
  logic        cell_valid;
  logic        cell_ready;
  logic [31:0] cell_data;
  logic [6:0]  cell_col;
  logic        cell_last;
  logic        busy;
  logic        line_done;

  logic [31:0] mem [128];

  int n_checks = 0;
  int n_fail   = 0;

  int fv, fd, ld, dc, nc, bd, ab;
  bit found;

  always #5 clk = ~clk;

  // Buffer read port: data for the address presented in cycle n appears in n+1.
  always @(posedge clk) ram_data <= mem[ram_addr];

  charattr_row_reader dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .cell_valid (cell_valid),
    .cell_ready (cell_ready),
    .cell_data  (cell_data),
    .cell_col   (cell_col),
    .cell_last  (cell_last),
    .busy       (busy),
    .line_done  (line_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns at cycle 1 of the new row.
  task automatic start_line();
    line_start = 1'b1;
    @(posedge clk);
    #1;
    line_start = 1'b0;
  endtask

  // mode 0: ready high; mode 1: ready on odd cycles; mode 2: ready low for 'stall' cycles.
  task automatic run_row(input int mode, input int stall, input int budget,
                         output int first_valid, output int first_done, output int last_done,
                         output int done_cnt, output int n_cells, output int bad,
                         output int ahead_bad);
    int next_col;
    first_valid = -1; first_done = -1; last_done = -1;
    done_cnt = 0; n_cells = 0; bad = 0; ahead_bad = 0; next_col = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      case (mode)
        1:       cell_ready = cyc[0];
        2:       cell_ready = (cyc > stall);
        default: cell_ready = 1'b1;
      endcase
      @(negedge clk);
      if (cyc == 1) check("busy_cycle1", 32'(busy), 32'd1);
      if (mode == 2 && cyc == stall) begin
        check("stall_valid", 32'(cell_valid), 32'd1);
        check("stall_col",   32'(cell_col),   32'd0);
        check("stall_data",  cell_data,       32'hA500_0000);
      end
      if (cell_valid && first_valid < 0) first_valid = cyc;
      if (int'(ram_addr) > next_col + 2) ahead_bad++;
      if (line_done) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
        last_done = cyc;
      end
      if (cell_valid && cell_ready) begin
        if (cell_data !== 32'hA500_0000 + 32'(next_col) || int'(cell_col) != next_col ||
            cell_last !== (next_col == 79))
          bad++;
        next_col++;
        n_cells++;
      end
      @(posedge clk);
      #1;
    end
    cell_ready = 1'b1;
  endtask

  // Streams with ready high until the head cell has column 'col'; returns at the falling edge.
  task automatic wait_col(input int col, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cell_ready = 1'b1;
      @(negedge clk);
      if (cell_valid && int'(cell_col) == col) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 + 32'(i);
    reset      = 1'b0;
    line_start = 1'b0;
    cell_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ram_addr",   32'(ram_addr),   32'd0);
    check("rst_cell_valid", 32'(cell_valid), 32'd0);
    check("rst_cell_data",  cell_data,       32'd0);
    check("rst_cell_col",   32'(cell_col),   32'd0);
    check("rst_cell_last",  32'(cell_last),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_line_done",  32'(line_done),  32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Full row, ready held high.
    start_line();
    run_row(0, 0, 90, fv, fd, ld, dc, nc, bd, ab);
    check("full_first_valid", 32'(fv), 32'd3);
    check("full_line_done",   32'(fd), 32'd83);
    check("full_done_count",  32'(dc), 32'd1);
    check("full_cells",       32'(nc), 32'd80);
    check("full_bad_cells",   32'(bd), 32'd0);
    check("full_addr_ahead",  32'(ab), 32'd0);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Ready toggling every cycle.
    start_line();
    run_row(1, 0, 200, fv, fd, ld, dc, nc, bd, ab);
    check("toggle_cells",      32'(nc), 32'd80);
    check("toggle_bad_cells",  32'(bd), 32'd0);
    check("toggle_done_count", 32'(dc), 32'd1);
    check("toggle_addr_ahead", 32'(ab), 32'd0);

    // Ready held low for 20 cycles after line_start.
    start_line();
    run_row(2, 20, 120, fv, fd, ld, dc, nc, bd, ab);
    check("stall_first_valid", 32'(fv), 32'd3);
    check("stall_line_done",   32'(fd), 32'd101);
    check("stall_cells",       32'(nc), 32'd80);
    check("stall_bad_cells",   32'(bd), 32'd0);
    check("stall_addr_ahead",  32'(ab), 32'd0);

    // Abort at column 40.
    start_line();
    wait_col(40, 100, found);
    check("abort_reach_col40", 32'(found), 32'd1);
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    run_row(0, 0, 90, fv, fd, ld, dc, nc, bd, ab);
    check("abort_first_valid", 32'(fv), 32'd3);
    check("abort_line_done",   32'(fd), 32'd83);
    check("abort_done_count",  32'(dc), 32'd1);
    check("abort_cells",       32'(nc), 32'd80);
    check("abort_bad_cells",   32'(bd), 32'd0);

    // Reset asserted at column 25.
    start_line();
    wait_col(25, 100, found);
    check("rstmid_reach_col25", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    check("rstmid_cell_valid", 32'(cell_valid), 32'd0);
    check("rstmid_ram_addr",   32'(ram_addr),   32'd0);
    check("rstmid_busy",       32'(busy),       32'd0);
    check("rstmid_cell_col",   32'(cell_col),   32'd0);
    check("rstmid_cell_data",  cell_data,       32'd0);
    check("rstmid_cell_last",  32'(cell_last),  32'd0);
    check("rstmid_line_done",  32'(line_done),  32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    start_line();
    run_row(0, 0, 90, fv, fd, ld, dc, nc, bd, ab);
    check("rstmid_row_first_valid", 32'(fv), 32'd3);
    check("rstmid_row_line_done",   32'(fd), 32'd83);
    check("rstmid_row_cells",       32'(nc), 32'd80);
    check("rstmid_row_bad_cells",   32'(bd), 32'd0);

    // line_start coinciding with the column-79 handshake.
    start_line();
    wait_col(79, 100, found);
    check("b2b_reach_col79", 32'(found), 32'd1);
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    run_row(0, 0, 90, fv, fd, ld, dc, nc, bd, ab);
    check("b2b_prev_line_done", 32'(fd), 32'd1);
    check("b2b_new_line_done",  32'(ld), 32'd83);
    check("b2b_done_count",     32'(dc), 32'd2);
    check("b2b_first_valid",    32'(fv), 32'd3);
    check("b2b_cells",          32'(nc), 32'd80);
    check("b2b_bad_cells",      32'(bd), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
